// File: rtl/i2s_rx_slave_if.sv
// i2s_rx_slave_if: groups the I2S serial inputs and the parallel stereo outputs
// of the I2S receive front end. The master modport is the stream source and the
// consumer of the outputs; the slave modport is the receiver itself.
`timescale 1ns/1ps
interface i2s_rx_slave_if #(
  parameter int WORD_W = 24
);
  logic              I2S_sclk;
  logic              I2S_ws;
  logic              I2S_data;
  logic [WORD_W-1:0] lft_chnnl;
  logic [WORD_W-1:0] rght_chnnl;
  logic              vld;
  logic              frm_err;

  modport master (
    output I2S_sclk, I2S_ws, I2S_data,
    input  lft_chnnl, rght_chnnl, vld, frm_err
  );

  modport slave (
    input  I2S_sclk, I2S_ws, I2S_data,
    output lft_chnnl, rght_chnnl, vld, frm_err
  );
endinterface

// File: rtl/i2s_rx_slave.sv
// i2s_rx_slave: I2S slave receiver. Oversamples sclk/ws/data in the clk domain,
// deserializes MSB-first left/right words and presents them as a registered
// stereo pair with a one-cycle vld strobe.
// Optional feature: define I2S_FRAME_CHK_EN to check ws against the expected
// framing on every bit; a violation pulses frm_err, drops the frame and
// re-enters SYNC. Without it, frm_err is constant 0 and ws is only used to lock.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_SYNC  | waiting for a ws fall (ws_prev=1, ws=0) to align to a frame
// ST_LEFT  | shifting the left word, bit_cnt = bits already received
// ST_RIGHT | shifting the right word, bit_cnt = bits already received
`timescale 1ns/1ps
module i2s_rx_slave #(
  parameter int WORD_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2s_rx_slave_if.slave         bus
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  w_bit_cnt_nxt;
  logic [WORD_W-2:0] r_shift;
  logic [WORD_W-2:0] w_shift_nxt;
  logic [WORD_W-1:0] w_word;
  logic              w_ld_lft;
  logic              w_ld_rght;
  logic              w_err;
  logic              w_last;
  logic              w_ws_bad;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_ws_s1, r_ws_s2;
  logic r_data_s1, r_data_s2;
  logic r_ws_prev;
  logic w_sclk_rise;

  logic [WORD_W-1:0] r_lft;
  logic [WORD_W-1:0] r_rght;
  logic              r_vld;
  logic              r_frm_err;

  // Two-flop synchronizers for all three I2S inputs plus a third sclk flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_ws_s1   <= 1'b0;
      r_ws_s2   <= 1'b0;
      r_data_s1 <= 1'b0;
      r_data_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= bus.I2S_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_ws_s1   <= bus.I2S_ws;
      r_ws_s2   <= r_ws_s1;
      r_data_s1 <= bus.I2S_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_last      = (r_bit_cnt == LAST_BIT);
  assign w_word      = {r_shift, r_data_s2};

  // ws must be low through the left word except its LSB, high through the right
  // word except its LSB (ws leads the data by one bit).
`ifdef I2S_FRAME_CHK_EN
  logic w_ws_exp;
  assign w_ws_exp = (r_state == ST_RIGHT) ? ~w_last : w_last;
  assign w_ws_bad = (r_ws_s2 != w_ws_exp);
`else
  assign w_ws_bad = 1'b0;
`endif

  // Remember ws from the previous sampled bit so SYNC can spot a ws fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws_prev <= 1'b0;
    end else if (w_sclk_rise) begin
      r_ws_prev <= r_ws_s2;
    end
  end

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SYNC;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic: lock on a ws fall, then frame purely by bit count.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ld_lft      = 1'b0;
    w_ld_rght     = 1'b0;
    w_err         = 1'b0;
    if (w_sclk_rise) begin
      case (r_state)
        ST_SYNC: begin
          // The bit on the ws-fall edge is the previous right LSB; drop it.
          if (!r_ws_s2 && r_ws_prev) begin
            w_state_nxt   = ST_LEFT;
            w_bit_cnt_nxt = '0;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (w_ws_bad) begin
            w_err         = 1'b1;
            w_state_nxt   = ST_SYNC;
            w_bit_cnt_nxt = '0;
          end else begin
            w_shift_nxt = w_word[WORD_W-2:0];
            if (w_last) begin
              w_bit_cnt_nxt = '0;
              if (r_state == ST_LEFT) begin
                w_ld_lft    = 1'b1;
                w_state_nxt = ST_RIGHT;
              end else begin
                w_ld_rght   = 1'b1;
                w_state_nxt = ST_LEFT;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt   = ST_SYNC;
          w_bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output registers; frm_err stays 0 when the framing check is not built in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lft     <= '0;
      r_rght    <= '0;
      r_vld     <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_ld_lft) begin
        r_lft <= w_word;
      end
      if (w_ld_rght) begin
        r_rght <= w_word;
      end
      r_vld     <= w_ld_rght;
      r_frm_err <= w_err;
    end
  end

  assign bus.lft_chnnl  = r_lft;
  assign bus.rght_chnnl = r_rght;
  assign bus.vld        = r_vld;
  assign bus.frm_err    = r_frm_err;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// tb_i2s_rx_slave: drives a prebuilt I2S slot stream (directed + random frames,
// a mid-word reset and an early ws toggle) and compares the observed vld/frm_err
// events against a frame-level reference computed from the same slot stream.
`timescale 1ns/1ps
module tb_i2s_rx_slave;

  localparam int W = 24;

  typedef struct {
    int         slot;
    logic [W-1:0] l;
    logic [W-1:0] r;
  } ev_t;

  logic clk;
  logic rst_n;

  i2s_rx_slave_if #(.WORD_W(W)) bus ();

  i2s_rx_slave #(.WORD_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit  ws_a[$];
  bit  d_a[$];
  time rise_t[$];
  int  rst_slot = -1;

  ev_t exp_v[$];
  ev_t exp_e[$];

  time          obs_vt[$];
  logic [W-1:0] obs_vl[$];
  logic [W-1:0] obs_vr[$];
  time          obs_et[$];
  logic [W-1:0] obs_el[$];
  logic [W-1:0] obs_er[$];
  int  vld_cyc = 0;
  int  err_cyc = 0;
  logic prev_vld = 1'b0;
  logic prev_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_slot(input bit w, input bit d);
    ws_a.push_back(w);
    d_a.push_back(d);
  endtask

  // One I2S frame: ws leads the data by one bit, so the LSB slot of each word
  // already carries the next channel's ws. `early` raises ws that many bits early.
  task automatic push_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int early);
    for (int b = 0; b < W; b++) push_slot(b >= (W - 1 - early), l[W-1-b]);
    for (int b = 0; b < W; b++) push_slot(b != (W - 1), r[W-1-b]);
  endtask

  task automatic push_rand_frame();
    push_frame(W'($urandom()), W'($urandom()), 0);
  endtask

  task automatic build_stream();
    // Stream joins 10 bits into a right word.
    for (int b = 10; b < W; b++) push_slot(b != (W - 1), 1'($urandom()));
    push_frame(24'h123456, 24'hABCDEF, 0);
    push_frame(24'h800000, 24'h7FFFFF, 0);
    push_frame(24'h000000, 24'hFFFFFF, 0);
    push_frame(24'h000001, 24'h800001, 0);
    for (int i = 0; i < 3; i++) push_rand_frame();
    rst_slot = ws_a.size() + W + 12;
    push_rand_frame();
    for (int i = 0; i < 2; i++) push_rand_frame();
    push_frame(W'($urandom()), W'($urandom()), 4);
    for (int i = 0; i < 2; i++) push_rand_frame();
    for (int i = 0; i < 5; i++) push_slot(1'b0, 1'($urandom()));
  endtask

  task automatic drive_stream();
    for (int j = 0; j < ws_a.size(); j++) begin
      bus.I2S_sclk = 1'b0;
      bus.I2S_ws   = ws_a[j];
      bus.I2S_data = d_a[j];
      if (j == rst_slot) begin
        #10 rst_n = 1'b0;
        #10;
        chk("rst_mid_lft", 32'(bus.lft_chnnl), 32'h0);
        chk("rst_mid_rght", 32'(bus.rght_chnnl), 32'h0);
        chk("rst_mid_vld", 32'(bus.vld), 32'h0);
        #10 rst_n = 1'b1;
        #20;
      end else begin
        #50;
      end
      bus.I2S_sclk = 1'b1;
      rise_t.push_back($time);
      #50;
    end
    bus.I2S_sclk = 1'b0;
  endtask

  // Frame-level reference: a reset splits the stream into independent segments.
  // In a segment, lock on the first ws fall (1 then 0 on consecutive sampled
  // slots, never on the segment's first slot); the next 2*W slots are one
  // left+right frame, vld belongs to its last slot. With the framing check,
  // the ws of each frame slot must match the ideal pattern, else frm_err at
  // the first bad slot and the search for a ws fall resumes after it.
  task automatic build_model();
    int lo, hi, j, base, outcome, bad_k;
    logic [W-1:0] last_l, last_r, l, r;
    bit ideal;
    for (int s = 0; s < 2; s++) begin
      lo = (s == 0) ? 0 : rst_slot;
      hi = (s == 0) ? rst_slot : ws_a.size();
      last_l = '0;
      last_r = '0;
      j = lo + 1;
      while (j < hi) begin
        if (!(ws_a[j-1] && !ws_a[j])) begin
          j++;
          continue;
        end
        base = j;
        outcome = 0;
        while (outcome == 0) begin
          bad_k = 0;
          for (int k = 1; k <= 2 * W; k++) begin
            if (base + k >= hi) begin
              outcome = 2;
              break;
            end
            ideal = (k >= W) && (k < 2 * W);
`ifdef I2S_FRAME_CHK_EN
            if (ws_a[base+k] != ideal) begin
              bad_k = k;
              outcome = 1;
              break;
            end
`else
            if (ideal) bad_k = 0;
`endif
          end
          if (outcome == 0) begin
            l = '0;
            r = '0;
            for (int k = 1; k <= W; k++) l = (l << 1) | W'(d_a[base+k]);
            for (int k = W + 1; k <= 2 * W; k++) r = (r << 1) | W'(d_a[base+k]);
            exp_v.push_back('{slot: base + 2 * W, l: l, r: r});
            last_l = l;
            last_r = r;
            base = base + 2 * W;
          end else if (outcome == 1) begin
            exp_e.push_back('{slot: base + bad_k, l: last_l, r: last_r});
            j = base + bad_k + 1;
          end else begin
            j = hi;
          end
        end
      end
    end
  endtask

  // Monitor: sample outputs on the falling clk edge, record each pulse once.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.vld) begin
        vld_cyc++;
        if (!prev_vld) begin
          obs_vt.push_back($time);
          obs_vl.push_back(bus.lft_chnnl);
          obs_vr.push_back(bus.rght_chnnl);
        end
      end
      if (bus.frm_err) begin
        err_cyc++;
        if (!prev_err) begin
          obs_et.push_back($time);
          obs_el.push_back(bus.lft_chnnl);
          obs_er.push_back(bus.rght_chnnl);
        end
      end
      prev_vld = bus.vld;
      prev_err = bus.frm_err;
    end else begin
      prev_vld = 1'b0;
      prev_err = 1'b0;
    end
  end

  task automatic compare();
    int  n;
    time lat;
    chk("vld_count", 32'(obs_vt.size()), 32'(exp_v.size()));
    chk("vld_cycles", 32'(vld_cyc), 32'(exp_v.size()));
    chk("err_count", 32'(obs_et.size()), 32'(exp_e.size()));
    chk("err_cycles", 32'(err_cyc), 32'(exp_e.size()));
    n = (obs_vt.size() < exp_v.size()) ? obs_vt.size() : exp_v.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("vld%0d_lft", i), 32'(obs_vl[i]), 32'(exp_v[i].l));
      chk($sformatf("vld%0d_rght", i), 32'(obs_vr[i]), 32'(exp_v[i].r));
      lat = obs_vt[i] - rise_t[exp_v[i].slot];
      chk($sformatf("vld%0d_latency_ns", i), 32'((lat >= 15 && lat <= 50) ? 0 : lat), 32'h0);
    end
    n = (obs_et.size() < exp_e.size()) ? obs_et.size() : exp_e.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("err%0d_lft_held", i), 32'(obs_el[i]), 32'(exp_e[i].l));
      chk($sformatf("err%0d_rght_held", i), 32'(obs_er[i]), 32'(exp_e[i].r));
      lat = obs_et[i] - rise_t[exp_e[i].slot];
      chk($sformatf("err%0d_latency_ns", i), 32'((lat >= 15 && lat <= 50) ? 0 : lat), 32'h0);
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    bus.I2S_sclk = 1'b0;
    bus.I2S_ws   = 1'b0;
    bus.I2S_data = 1'b0;
    build_stream();
    #3 rst_n = 1'b0;
    #19;
    chk("rst_lft", 32'(bus.lft_chnnl), 32'h0);
    chk("rst_rght", 32'(bus.rght_chnnl), 32'h0);
    chk("rst_vld", 32'(bus.vld), 32'h0);
    chk("rst_frm_err", 32'(bus.frm_err), 32'h0);
    #20 rst_n = 1'b1;
    #960;
    drive_stream();
    #2000;
    build_model();
    compare();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
